// File: rtl/block_scan_counter_pkg.sv
// Shared codec definitions for the block scan counter: scan FSM states and
// default geometry for 8x8 block tiling.
package block_scan_counter_pkg;

    localparam int DEF_NUM_DIMS = 4;
    localparam int DEF_WIDTH    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/block_scan_counter_if.sv
// Control and index-stream bundle between the frame controller, the scan
// counter and the block fetch pipeline.
interface block_scan_counter_if
    import block_scan_counter_pkg::*;
#(
    parameter int NUM_DIMS = DEF_NUM_DIMS,
    parameter int WIDTH    = DEF_WIDTH
);

    logic                      start;
    logic [NUM_DIMS*WIDTH-1:0] limits;
    logic                      abort;
    logic                      ready;
    logic                      valid;
    logic [NUM_DIMS*WIDTH-1:0] idx;
    logic [NUM_DIMS-1:0]       wrap;
    logic                      last;
    logic                      done;
    logic                      busy;

    // Frame controller / consumer side
    modport master (
        output start, limits, abort, ready,
        input  valid, idx, wrap, last, done, busy
    );

    // Scan counter side
    modport slave (
        input  start, limits, abort, ready,
        output valid, idx, wrap, last, done, busy
    );

endinterface

// File: rtl/block_scan_counter_scan_dim.sv
// One dimension of the scan odometer: holds its index and latched limit,
// steps on carry-in and rolls over to zero at the limit.
module scan_dim
    import block_scan_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] lim_in,
    input  logic             clear,
    input  logic             carry_in,
    output logic [WIDTH-1:0] idx,
    output logic             at_limit,
    output logic             carry_out
);

    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lim_q <= '0;
        end else if (load) begin
            lim_q <= lim_in;
        end
    end

    // The index never passes its limit, so the WIDTH-bit increment cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (load || clear) begin
            idx_q <= '0;
        end else if (carry_in) begin
            idx_q <= at_limit ? '0 : idx_q + WIDTH'(1);
        end
    end

    assign at_limit  = (idx_q == lim_q);
    assign carry_out = carry_in & at_limit;
    assign idx       = idx_q;

endmodule

// File: rtl/block_scan_counter.sv
// Multi-dimensional scan counter: start/abort FSM around a carry-chained
// array of scan_dim counters, streaming nested loop indices with valid/ready.
module block_scan_counter
    import block_scan_counter_pkg::*;
#(
    parameter int NUM_DIMS = DEF_NUM_DIMS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    block_scan_counter_if.slave  bus
);

    scan_state_t state_q;
    scan_state_t state_d;

    logic                      load;
    logic                      handshake;
    logic [NUM_DIMS:0]         carry;
    logic [NUM_DIMS-1:0]       at_lim;
    logic [NUM_DIMS-1:0]       wrap_chain;
    logic [NUM_DIMS*WIDTH-1:0] idx_vec;
    logic                      run;

    assign run       = (state_q == ST_RUN);
    assign handshake = run & bus.ready;

    // Every handshake feeds dim 0; the carry out of the top dim marks the
    // final handshake, which also rolls all dims back to zero.
    assign carry[0] = handshake;

    for (genvar g = 0; g < NUM_DIMS; g++) begin : g_dim
        scan_dim #(
            .WIDTH (WIDTH)
        ) u_dim (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .lim_in    (bus.limits[g*WIDTH +: WIDTH]),
            .clear     (bus.abort),
            .carry_in  (carry[g]),
            .idx       (idx_vec[g*WIDTH +: WIDTH]),
            .at_limit  (at_lim[g]),
            .carry_out (carry[g+1])
        );

        if (g == 0) begin : g_wrap0
            assign wrap_chain[g] = at_lim[g];
        end else begin : g_wrapn
            assign wrap_chain[g] = wrap_chain[g-1] & at_lim[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (carry[NUM_DIMS]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.abort) begin
            state_d = ST_IDLE;
        end
    end

    assign bus.valid = run;
    assign bus.done  = (state_q == ST_DONE);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.idx   = idx_vec;
    assign bus.wrap  = run ? wrap_chain : '0;
    assign bus.last  = run & wrap_chain[NUM_DIMS-1];

endmodule

// File: doc/block_scan_counter.md
# block_scan_counter

Parametrised multi-dimensional scan counter that generates nested loop indices (for example column-in-block, row-in-block, block-column, block-row) for the image codec's tile traversal. It is the successor to the single-dimension enable/restart counter. It adds:
- a runtime-loaded limit per dimension,
- per-dimension carry/wrap flags,
- a valid/ready output handshake,
- a start/abort control FSM with a single-cycle completion pulse.

It sits between the frame controller and the block fetch/transform pipeline.

## Interface
- NUM_DIMS, 4, number of nested dimensions; dim 0 is innermost (fastest).
- WIDTH, 8, bits per dimension index and limit.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load `limits` and begin a scan; honoured only in IDLE.
- limits  in  NUM_DIMS*WIDTH  inclusive max index per dim; dim i at bits [i*WIDTH +: WIDTH]; sampled only on an accepted start.
- abort  in  1  cancel scan immediately; highest priority.
- ready  in  1  downstream accepts current index.
- valid  out  1  `idx` is a valid scan point.
- idx  out  NUM_DIMS*WIDTH  current index vector, same packing as `limits`.
- wrap  out  NUM_DIMS  wrap[i]=1: dim i rolls over to 0 on the current handshake.
- last  out  1  current index is the final point of the scan.
- done  out  1  one-cycle pulse after the final handshake.
- busy  out  1  scan in progress (RUN or DONE state).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start (abort=0): latch limits, clear idx.
  - RUN -> DONE on a handshake (valid&ready) while last=1.
  - DONE -> IDLE unconditionally after one cycle.
  - Any state -> IDLE on abort, with idx cleared and no done pulse.
- valid = (state==RUN).
- done = (state==DONE).
- busy = (state!=IDLE).
- Handshake in RUN with last=0 advances the index as an odometer:
  - dim 0 increments.
  - A dim at its limit resets to 0 and carries into the next dim.
  - Higher dims hold unless carried into.
- wrap[0] = (idx0==lim0).
- wrap[i] = wrap[i-1] & (idx_i==lim_i).
- last = wrap[NUM_DIMS-1].
- wrap and last are combinational from registers and are meaningful only while valid=1; they read 0 when valid=0.
- A limit of 0 makes that dim constant 0 and permanently at-limit; its carry passes straight through.
- All limits 0: exactly one point; last=1 on the first valid cycle.
- Total points per scan = product of (lim_i+1).
- Width rule: the incrementer is WIDTH bits. A dim never exceeds its limit, so the counter never wraps past 2^WIDTH-1. A limit of 2^WIDTH-1 is legal.
- ready without valid has no effect.
- start outside IDLE is ignored; limits are not re-sampled.
- start and abort in the same cycle: abort wins and the FSM stays IDLE.

## Timing
- Reset values: state=IDLE, idx=0, latched limits=0, valid=0, done=0, busy=0. Therefore wrap=0 and last=0.
- start accepted at cycle t: valid=1, idx=0 at t+1.
- Each handshake at cycle t: new idx visible at t+1. Throughput is one point per cycle with ready held high.
- Final handshake at t: valid=0 and done=1 at t+1; busy=0 at t+2. The earliest next start is accepted at t+2.
- abort at t: valid=0, busy=0, idx=0 at t+1.
- Asynchronous reset mid-scan forces reset values immediately; the scan is not resumed.
- Minimum scan of N points with ready=1: start to done pulse spans N+1 cycles.

## Structure
- Shared codec package holds:
  - the scan FSM state enum (IDLE, RUN, DONE);
  - default NUM_DIMS and WIDTH constants for 8x8 block tiling.
- One sub-module, `scan_dim`: a single dimension with a register for index and limit, an increment/clear on carry-in, and a carry-out when at limit. Generate NUM_DIMS instances chained by carry.
- The top level holds the FSM and output decode.

## Test plan
- Reset, then limits={3,2,1,7} (dim0=7), start, ready=1 throughout -> 8*2*3*4=192 valid cycles in raster order; last=1 only at idx {3,2,1,7}; done pulses once at cycle 193 after start.
- Limits dim0=7, dim1=7, ready toggled 1,0 every cycle -> idx advances only on ready=1 cycles; wrap[0]=1 exactly when dim0=7; wrap[1]=1 only at {7,7}.
- All limits 0 -> single valid cycle with idx=0, last=1, all wrap=1; done one cycle later.
- Limits 255 on dim0 (WIDTH=8), others 0 -> 256 points; dim0 runs 0..255 with no overflow; done follows.
- abort at the 10th point of a 64-point scan -> valid=0 and idx=0 next cycle; no done pulse. A start in the same cycle as abort is ignored.
- start pulsed in RUN with different limits -> ignored; the scan completes with the original limits. Async rst_n low mid-scan -> all outputs 0 immediately.
